sc_speed_tick_generator: RTL

//  Upstream stage of the up-speed counter. Divides CLOCK_50 into a one-cycle,

---
 rtl/sc_speed_tick_generator_pkg.sv | 30 +++
 rtl/sc_speed_tick_generator_press_detect.sv | 76 +++++++
 rtl/sc_speed_tick_generator.sv | 98 +++++++++
 3 files changed

// File: rtl/sc_speed_tick_generator_pkg.sv
// Shared definitions for the speed tick generator: button FSM states,
// level ceiling and tick period helpers.
package sc_speed_tick_generator_pkg;

   // Press-detect FSM: IDLE waits for a stable press, HELD waits for a stable release
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } btn_state_e;

   // Index of the button in the packed button/event vectors
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_PAUSE = 2;
   localparam int unsigned NUM_BTN   = 3;

   // Highest speed level for a given level width
   function automatic int unsigned level_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   // Tick period for a level: base halved per level, never below one clock
   function automatic int unsigned clamp_period(input int unsigned base,
                                                input int unsigned lvl);
      int unsigned p;
      p = (lvl >= 32) ? 32'd0 : (base >> lvl);
      return (p == 0) ? 32'd1 : p;
   endfunction

endpackage

// File: rtl/sc_speed_tick_generator_press_detect.sv
// Raw push-button to one-cycle press event: 2-FF synchronizer followed by a
// debounce counter and an IDLE/HELD FSM. Buttons are active low.
module sc_button_press_detect
   import sc_speed_tick_generator_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned DEBOUNCE_WIDTH  = 19
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                      sync1;
   logic                      sync2;
   logic [DEBOUNCE_WIDTH-1:0] cnt;
   btn_state_e                state;

   // Synchronize the asynchronous button; idles released (1)
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   // Debounce FSM: a level must persist DEBOUNCE_CYCLES clocks to change state;
   // only the IDLE->HELD transition emits an event
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!sync2) begin
                  if (cnt == CNT_LAST) begin
                     state <= ST_HELD;
                     cnt   <= '0;
                     press <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ST_HELD: begin
               if (sync2) begin
                  if (cnt == CNT_LAST) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sc_speed_tick_generator.sv
// Speed tick generator: divides the system clock into a one-cycle active-low
// count-enable tick whose rate is set by debounced up/down buttons, with a
// pause toggle that freezes the prescaler.
module sc_speed_tick_generator
   import sc_speed_tick_generator_pkg::*;
#(
   parameter int unsigned BASE_PERIOD     = 25_000_000,
   parameter int unsigned PRESCALER_WIDTH = 25,
   parameter int unsigned LEVEL_WIDTH     = 3,
   parameter int unsigned DEFAULT_LEVEL   = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned DEBOUNCE_WIDTH  = 19
) (
   input  logic                   SC_SPEEDTICKGEN_CLOCK_50,
   input  logic                   SC_SPEEDTICKGEN_RESET_InHigh,
   input  logic                   SC_SPEEDTICKGEN_speedUp_InLow,
   input  logic                   SC_SPEEDTICKGEN_speedDown_InLow,
   input  logic                   SC_SPEEDTICKGEN_pause_InLow,
   output logic                   SC_SPEEDTICKGEN_tick_OutLow,
   output logic [LEVEL_WIDTH-1:0] SC_SPEEDTICKGEN_level_OutBUS,
   output logic                   SC_SPEEDTICKGEN_paused_OutHigh
);

   localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP  = LEVEL_WIDTH'(level_max(LEVEL_WIDTH));
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_INIT = LEVEL_WIDTH'(DEFAULT_LEVEL);

   logic                       clk;
   logic                       rst;
   logic [NUM_BTN-1:0]         btn_n;
   logic [NUM_BTN-1:0]         evt;
   logic [LEVEL_WIDTH-1:0]     level;
   logic                       paused;
   logic                       tick_n;
   logic [PRESCALER_WIDTH-1:0] prescaler;
   logic [PRESCALER_WIDTH-1:0] period_m1;
   logic                       go_up;
   logic                       go_down;

   assign clk              = SC_SPEEDTICKGEN_CLOCK_50;
   assign rst              = SC_SPEEDTICKGEN_RESET_InHigh;
   assign btn_n[BTN_UP]    = SC_SPEEDTICKGEN_speedUp_InLow;
   assign btn_n[BTN_DOWN]  = SC_SPEEDTICKGEN_speedDown_InLow;
   assign btn_n[BTN_PAUSE] = SC_SPEEDTICKGEN_pause_InLow;

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      sc_button_press_detect #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
      ) u_detect (
         .clk   (clk),
         .rst   (rst),
         .btn_n (btn_n[b]),
         .press (evt[b])
      );
   end

   // Wrap point of the prescaler for the current level
   always_comb begin
      period_m1 = PRESCALER_WIDTH'(clamp_period(BASE_PERIOD, 32'(level)) - 32'd1);
   end

   // Simultaneous up/down cancel; saturated presses are not a change
   always_comb begin
      go_up   = evt[BTN_UP]   && !evt[BTN_DOWN] && (level != LEVEL_TOP);
      go_down = evt[BTN_DOWN] && !evt[BTN_UP]   && (level != '0);
   end

   // Level, pause flag, prescaler and registered tick
   always_ff @(posedge clk) begin
      if (rst) begin
         level     <= LEVEL_INIT;
         paused    <= 1'b0;
         prescaler <= '0;
         tick_n    <= 1'b1;
      end else begin
         if (evt[BTN_PAUSE]) paused <= ~paused;
         if (go_up || go_down) begin
            // A rate change restarts the period, even while paused
            level     <= go_up ? level + 1'b1 : level - 1'b1;
            prescaler <= '0;
            tick_n    <= 1'b1;
         end else if (paused) begin
            tick_n <= 1'b1;
         end else if (prescaler == period_m1) begin
            prescaler <= '0;
            tick_n    <= 1'b0;
         end else begin
            prescaler <= prescaler + 1'b1;
            tick_n    <= 1'b1;
         end
      end
   end

   assign SC_SPEEDTICKGEN_tick_OutLow    = tick_n;
   assign SC_SPEEDTICKGEN_level_OutBUS   = level;
   assign SC_SPEEDTICKGEN_paused_OutHigh = paused;

endmodule
